// File: rtl/execute_stage_if.sv
// Execute-stage bus: decoded instruction in, registered E->M stage, live CC and status out.
// master = upstream/decode side, slave = execute_stage.
interface execute_stage_if #(parameter int DATA_W = 64);
  logic              e_valid;
  logic              e_stall;
  logic [3:0]        icode;
  logic [3:0]        ifun;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic [DATA_W-1:0] valC;
  logic              m_valid;
  logic [3:0]        m_icode;
  logic [3:0]        m_rA;
  logic [3:0]        m_rB;
  logic [DATA_W-1:0] m_valE;
  logic [DATA_W-1:0] m_valA;
  logic              m_Cnd;
  logic [1:0]        m_stat;
  logic [2:0]        cc;
  logic              halted;
  logic              state_dbg;

  // e_valid marks a real instruction; e_stall is a back-pressure hold: while it is
  // high nothing is consumed and every m_* output plus cc keeps its value.
  modport master (
    output e_valid, e_stall, icode, ifun, rA, rB, valA, valB, valC,
    input  m_valid, m_icode, m_rA, m_rB, m_valE, m_valA, m_Cnd, m_stat, cc, halted, state_dbg
  );
  modport slave (
    input  e_valid, e_stall, icode, ifun, rA, rB, valA, valB, valC,
    output m_valid, m_icode, m_rA, m_rB, m_valE, m_valA, m_Cnd, m_stat, cc, halted, state_dbg
  );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, Cnd evaluation, registered E->M output and RUN/HALTED FSM.
// Optional feature macro: EXEC_MULQ_EN enables OPq ifun 4 (mulq).
module execute_stage #(
  parameter int DATA_W = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  execute_stage_if.slave  bus
);
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_INS = 2'd2;
  localparam int MSB = DATA_W - 1;

  typedef enum logic [0:0] {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_m_valid;
  logic [3:0]        r_m_icode;
  logic [3:0]        r_m_rA;
  logic [3:0]        r_m_rB;
  logic [DATA_W-1:0] r_m_valE;
  logic [DATA_W-1:0] r_m_valA;
  logic              r_m_cnd;
  logic [1:0]        r_m_stat;
  logic [2:0]        r_cc;

  logic              w_accept;
  logic [DATA_W-1:0] w_valE;
  logic              w_cnd;
  logic [1:0]        w_stat;
  logic              w_cc_we;
  logic              w_of;
  logic              w_cond;
  logic              w_cond_ok;
  logic              w_zf;
  logic              w_sf;
  logic              w_ofl;
`ifdef EXEC_MULQ_EN
  logic [2*DATA_W-1:0] w_prod;
`endif

  assign w_zf  = r_cc[2];
  assign w_sf  = r_cc[1];
  assign w_ofl = r_cc[0];
  assign w_accept = bus.e_valid & ~bus.e_stall & (r_state == S_RUN);

  // Branch/cmov condition from the CC as it stands before this edge.
  always_comb begin
    w_cond    = 1'b0;
    w_cond_ok = 1'b1;
    case (bus.ifun)
      4'd0:    w_cond = 1'b1;
      4'd1:    w_cond = (w_sf ^ w_ofl) | w_zf;
      4'd2:    w_cond = w_sf ^ w_ofl;
      4'd3:    w_cond = w_zf;
      4'd4:    w_cond = ~w_zf;
      4'd5:    w_cond = ~(w_sf ^ w_ofl);
      4'd6:    w_cond = ~(w_sf ^ w_ofl) & ~w_zf;
      default: w_cond_ok = 1'b0;
    endcase
  end

`ifdef EXEC_MULQ_EN
  assign w_prod = $signed({{DATA_W{bus.valB[MSB]}}, bus.valB}) *
                  $signed({{DATA_W{bus.valA[MSB]}}, bus.valA});
`endif

  always_comb begin
    w_valE  = '0;
    w_cnd   = 1'b0;
    w_stat  = STAT_AOK;
    w_cc_we = 1'b0;
    w_of    = 1'b0;
    case (bus.icode)
      4'h0: w_stat = STAT_HLT;
      4'h1: ;
      4'h2, 4'h7: begin
        if (bus.icode == 4'h2) w_valE = bus.valA;
        if (w_cond_ok) w_cnd = w_cond;
        else           w_stat = STAT_INS;
      end
      4'h3: w_valE = bus.valC;
      4'h4, 4'h5: w_valE = bus.valB + bus.valC;
      4'h6: begin
        w_cc_we = 1'b1;
        case (bus.ifun)
          4'd0: begin
            w_valE = bus.valB + bus.valA;
            w_of   = (bus.valA[MSB] == bus.valB[MSB]) && (w_valE[MSB] != bus.valA[MSB]);
          end
          4'd1: begin
            w_valE = bus.valB - bus.valA;
            w_of   = (bus.valA[MSB] != bus.valB[MSB]) && (w_valE[MSB] != bus.valB[MSB]);
          end
          4'd2: w_valE = bus.valB & bus.valA;
          4'd3: w_valE = bus.valB ^ bus.valA;
`ifdef EXEC_MULQ_EN
          4'd4: begin
            w_valE = w_prod[DATA_W-1:0];
            w_of   = (w_prod[2*DATA_W-1:DATA_W] != {DATA_W{w_prod[MSB]}});
          end
`endif
          default: w_stat = STAT_INS;
        endcase
      end
      4'h8, 4'hA: w_valE = bus.valB - DATA_W'(8);
      4'h9, 4'hB: w_valE = bus.valB + DATA_W'(8);
      default: w_stat = STAT_INS;
    endcase
    // Any INS result is squashed so it cannot leak a partial value or touch CC.
    if (w_stat == STAT_INS) begin
      w_valE  = '0;
      w_cnd   = 1'b0;
      w_cc_we = 1'b0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_accept && (w_stat != STAT_AOK)) w_state_next = S_HALTED;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_icode <= 4'h1;
      r_m_rA    <= '0;
      r_m_rB    <= '0;
      r_m_valE  <= '0;
      r_m_valA  <= '0;
      r_m_cnd   <= 1'b0;
      r_m_stat  <= STAT_AOK;
      r_cc      <= 3'b100;
    end else if (!bus.e_stall) begin
      if (r_state == S_HALTED) begin
        // Only m_valid drops; m_stat keeps the terminating code.
        r_m_valid <= 1'b0;
      end else if (bus.e_valid) begin
        r_m_valid <= 1'b1;
        r_m_icode <= bus.icode;
        r_m_rA    <= bus.rA;
        r_m_rB    <= bus.rB;
        r_m_valE  <= w_valE;
        r_m_valA  <= bus.valA;
        r_m_cnd   <= w_cnd;
        r_m_stat  <= w_stat;
        if (w_cc_we) r_cc <= {(w_valE == '0), w_valE[MSB], w_of};
      end else begin
        r_m_valid <= 1'b0;
        r_m_icode <= 4'h1;
        r_m_valE  <= '0;
        r_m_cnd   <= 1'b0;
        r_m_stat  <= STAT_AOK;
      end
    end
  end

  assign bus.m_valid   = r_m_valid;
  assign bus.m_icode   = r_m_icode;
  assign bus.m_rA      = r_m_rA;
  assign bus.m_rB      = r_m_rB;
  assign bus.m_valE    = r_m_valE;
  assign bus.m_valA    = r_m_valA;
  assign bus.m_Cnd     = r_m_cnd;
  assign bus.m_stat    = r_m_stat;
  assign bus.cc        = r_cc;
  assign bus.halted    = (r_state == S_HALTED);
  assign bus.state_dbg = r_state;
endmodule
